sm1: RTL and testbench
======================

# sm1

Clocked Moore state machine that detects runs of three or more consecutive 1s on a serial input `x`. It raises output `y` while the run lasts and exposes its 2-bit state for observation. It is a standalone lab block driven by one clock, one active-low synchronous reset and one data bit.

## Interface
- No parameters.
- `clk`  input  1  system clock; every register updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `x`  input  1  serial data bit, sampled on the rising edge of `clk`.
- `y`  output  1  detection flag; 1 exactly when `state` = S3.
- `state`  output  2  current state register, driven directly from the flop.

## Operation
- States and encodings:
  - S0 = 2'b00: no 1s seen.
  - S1 = 2'b01: one 1 seen.
  - S2 = 2'b10: two consecutive 1s seen.
  - S3 = 2'b11: three or more consecutive 1s seen.
- Transitions, evaluated at each rising edge with `rst` = 1:
  - x=0: any state goes to S0.
  - x=1: S0 goes to S1, S1 goes to S2, S2 goes to S3, S3 stays in S3 (saturates).
- Output is Moore: `y` = (state == S3), decoded combinationally from the state register only. `x` has no combinational path to `y`.
- Reset: `rst` = 0 at a rising edge forces state to S0, which gives `y` = 0. Reset overrides `x`.
- All four 2-bit codes are legal, so no illegal-state recovery is required.

## Timing
- Both outputs are valid from the rising edge that registers the state. There is no handshake.
- Latency:
  - The third consecutive sampled 1 is sampled at edge N.
  - `state` becomes 2'b11 and `y` becomes 1 at edge N; both are visible after clock-to-Q.
  - The first sampled 0 after the run returns `state` to S0 and `y` to 0 at that same edge.
- Before the first reset edge, the state is undefined. The bench must assert reset for at least one edge.
- Reset asserted mid-run (for example in S2 or S3) clears to S0 on that edge. Counting restarts from zero after release.
- Release edge: reset is still effective on any edge where `rst` = 0. The first edge with `rst` = 1 applies the normal transition from S0.
- Inputs must be stable around the rising edge. There is no synchronizer on `x`.

## Structure
- Shared package `sm1_pkg`:
  - 2-bit state type with enum constants S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11.
  - Constant `RUN_LEN = 3`, for documentation only.
- Top `sm1` contains:
  - the state register with synchronous active-low reset;
  - the output decode.
- One combinational sub-module `sm1_next_state` (ports: `state_i`, `x_i`, `next_o`) holds the transition table so it can be checked exhaustively on its own.

## Test plan
Clock period is 10 ns, with rising edges at 5 ns + 10k.

1. Reset: `rst` = 0 for 2 edges with x=0, then `rst` = 1 with x=0 for 2 edges -> state=00, y=0 throughout.
2. Two 1s then a 0: x=1 for 2 edges, then x=0 -> state goes 01, 10, then 00; y stays 0.
3. Single-cycle 1: x=1 for exactly 1 edge, then x=0 -> state 01 then 00; y=0.
4. Run of five 1s: x=1 for 5 edges -> state 01, 10, 11, 11, 11; y=1 from the third edge through the fifth. Then x=0 for 1 edge -> state=00, y=0.
5. Reset mid-run: reach S3 with x=1, then drive `rst` = 0 with x held at 1 -> state=00 and y=0 on that edge. Release `rst` with x=1 -> state 01, 10, 11 on the following edges.
6. Exhaustive `sm1_next_state`: all 8 (state, x) combinations -> next state matches the transition list in Operation.

Source files
------------

// File: rtl/sm1_pkg.sv
// Shared types and constants for the sm1 run-of-ones detector.
package sm1_pkg;

  // One code per count of consecutive 1s seen; S3 saturates at "three or more".
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  // Length of the run that raises y. The state encoding above already fixes it,
  // so this is here for readers only.
  localparam int RUN_LEN = 3;

endpackage : sm1_pkg

// File: rtl/sm1_next_state.sv
// Transition table for sm1: counts consecutive 1s on x, saturating at S3,
// and drops back to S0 on any 0. Purely combinational.
module sm1_next_state
  import sm1_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic       x_i,
  output logic [1:0] next_o
);

  state_t cur_state;
  state_t nxt_state;

  assign cur_state = state_t'(state_i);
  assign next_o    = nxt_state;

  // Advance one step per sampled 1, hold in S3, clear on a 0.
  always_comb begin
    nxt_state = S0;
    if (x_i) begin
      case (cur_state)
        S0:      nxt_state = S1;
        S1:      nxt_state = S2;
        S2:      nxt_state = S3;
        S3:      nxt_state = S3;
        default: nxt_state = S0;
      endcase
    end
  end

endmodule : sm1_next_state

// File: rtl/sm1.sv
// sm1: Moore detector for runs of three or more consecutive 1s on x.
// y is decoded from the state flop only, so x never reaches y combinationally.
module sm1
  import sm1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic       y,
  output logic [1:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] next_w;

  sm1_next_state u_next_state (
    .state_i (state_q),
    .x_i     (x),
    .next_o  (next_w)
  );

  // Next-state value straight from the transition table.
  always_comb begin
    state_d = state_t'(next_w);
  end

  // State register; an active-low rst at the edge wins over x.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;
  assign y     = (state_q == S3);

endmodule : sm1

// File: tb/tb_sm1.sv
// Directed bench for sm1: a vector table applied one clock edge per entry,
// plus hand-written checks for Moore output timing and the transition table.
module tb_sm1;

  typedef struct {
    logic       rst;
    logic       x;
    logic [1:0] exp_state;
    logic       exp_y;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       x;
  logic       y;
  logic [1:0] state;

  logic [1:0] ns_state;
  logic       ns_x;
  logic [1:0] ns_next;

  int   n_applied;
  int   n_miscompare;
  vec_t vecs[$];

  sm1 dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .y     (y),
    .state (state)
  );

  sm1_next_state u_ns (
    .state_i (ns_state),
    .x_i     (ns_x),
    .next_o  (ns_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic xi, input logic [1:0] s, input logic yy);
    vec_t v;
    v.rst       = r;
    v.x         = xi;
    v.exp_state = s;
    v.exp_y     = yy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [1:0] s_req, input logic y_req);
    n_applied++;
    if (state !== s_req || y !== y_req) begin
      n_miscompare++;
      $display("FAIL %s: state=%b y=%b, required state=%b y=%b", name, state, y, s_req, y_req);
    end else begin
      $display("ok   %s: state=%b y=%b", name, state, y);
    end
  endtask

  logic [1:0] ns_exp [8];

  initial begin
    n_applied    = 0;
    n_miscompare = 0;
    rst          = 1'b0;
    x            = 1'b0;
    ns_state     = 2'b00;
    ns_x         = 1'b0;

    // 1. reset held two edges, then released with x=0
    add(0, 0, 2'b00, 0); add(0, 0, 2'b00, 0);
    add(1, 0, 2'b00, 0); add(1, 0, 2'b00, 0);
    // 2. two 1s then a 0
    add(1, 1, 2'b01, 0); add(1, 1, 2'b10, 0); add(1, 0, 2'b00, 0);
    // 3. single 1
    add(1, 1, 2'b01, 0); add(1, 0, 2'b00, 0);
    // 4. run of five 1s, then a 0
    add(1, 1, 2'b01, 0); add(1, 1, 2'b10, 0); add(1, 1, 2'b11, 1);
    add(1, 1, 2'b11, 1); add(1, 1, 2'b11, 1); add(1, 0, 2'b00, 0);
    // 5. reset in S3 with x=1, then release with x=1
    add(1, 1, 2'b01, 0); add(1, 1, 2'b10, 0); add(1, 1, 2'b11, 1);
    add(0, 1, 2'b00, 0);
    add(1, 1, 2'b01, 0); add(1, 1, 2'b10, 0); add(1, 1, 2'b11, 1);
    // reset from S2 over two edges, counting restarts after release
    add(1, 0, 2'b00, 0); add(1, 1, 2'b01, 0); add(1, 1, 2'b10, 0);
    add(0, 1, 2'b00, 0); add(0, 0, 2'b00, 0); add(1, 1, 2'b01, 0);
    add(1, 0, 2'b00, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      x   = vecs[i].x;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rst=%b x=%b", i, vecs[i].rst, vecs[i].x),
            vecs[i].exp_state, vecs[i].exp_y);
    end

    // Moore output: x changing between edges must not move y or state.
    rst = 1'b1;
    x   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("seq S2 reached", 2'b10, 1'b0);
    #2;
    check("seq S2 x held 1 mid-cycle", 2'b10, 1'b0);
    @(posedge clk); #1;
    check("seq S3 reached", 2'b11, 1'b1);
    x = 1'b0;
    #2;
    check("seq S3 x dropped mid-cycle", 2'b11, 1'b1);
    @(posedge clk); #1;
    check("seq S3 cleared by 0", 2'b00, 1'b0);

    // Exhaustive transition table, indexed by {state, x}.
    ns_exp[0] = 2'b00; ns_exp[1] = 2'b01;
    ns_exp[2] = 2'b00; ns_exp[3] = 2'b10;
    ns_exp[4] = 2'b00; ns_exp[5] = 2'b11;
    ns_exp[6] = 2'b00; ns_exp[7] = 2'b11;
    for (int k = 0; k < 8; k++) begin
      ns_state = k[2:1];
      ns_x     = k[0];
      #1;
      n_applied++;
      if (ns_next !== ns_exp[k]) begin
        n_miscompare++;
        $display("FAIL next_state s=%b x=%b: next=%b, required %b", ns_state, ns_x, ns_next, ns_exp[k]);
      end else begin
        $display("ok   next_state s=%b x=%b: next=%b", ns_state, ns_x, ns_next);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

endmodule : tb_sm1
